// File: rtl/day27_serial_comparator.sv
// Bit-serial magnitude comparator.
// It captures an unsigned operand pair and scans the pair from the MSB downward,
// one bit per clock. It stops at the first differing bit, or after the LSB when
// every bit matches. The result and the number of bit positions examined are held
// under a valid/ready handshake until the consumer takes them.
`timescale 1ns/1ps
module day27_serial_comparator #(
  parameter int K  = 20,
  parameter int CW = $clog2(K + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [K-1:0]  a,
  input  logic [K-1:0]  b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          a_equal_b,
  output logic          a_greater_b,
  output logic          b_greater_a,
  output logic [CW-1:0] cycles
);

  localparam int IW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [K-1:0]   a_reg;
  logic [K-1:0]   b_reg;
  logic [IW-1:0]  idx;
  logic [CW-1:0]  count;
  logic           bit_a;
  logic           bit_b;

  // Bits of the captured operands that are under examination this cycle.
  assign bit_a = a_reg[idx];
  assign bit_b = b_reg[idx];

  // The block accepts a new pair only while it is idle, so in_ready follows the state alone.
  assign in_ready = (state == IDLE);

  // Capture, serial scan and result hold, all in one registered FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the operand registers are datapath storage, but they are reset as well.
      // A reset then leaves nothing from an aborted scan that could leak into the next one.
      state       <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      idx         <= '0;
      count       <= '0;
      out_valid   <= 1'b0;
      a_equal_b   <= 1'b0;
      a_greater_b <= 1'b0;
      b_greater_a <= 1'b0;
      cycles      <= '0;
    end else begin
      // NOTE: every state register uses <=, so each right-hand side below reads the
      // value from before this edge. For that reason count + 1 is the number of
      // positions examined, including the bit being compared now.
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b;
            idx   <= IW'(K - 1);
            count <= '0;
            state <= SCAN;
          end
        end

        SCAN: begin
          count <= count + CW'(1);
          if (bit_a != bit_b) begin
            a_greater_b <= bit_a;
            b_greater_a <= bit_b;
            out_valid   <= 1'b1;
            cycles      <= count + CW'(1);
            state       <= DONE;
          end else if (idx == '0) begin
            a_equal_b <= 1'b1;
            out_valid <= 1'b1;
            cycles    <= count + CW'(1);
            state     <= DONE;
          end else begin
            idx <= idx - IW'(1);
          end
        end

        DONE: begin
          // Hold the result until the consumer takes it. in_valid is ignored here.
          // cycles keeps its value after the result is taken.
          if (out_ready) begin
            out_valid   <= 1'b0;
            a_equal_b   <= 1'b0;
            a_greater_b <= 1'b0;
            b_greater_a <= 1'b0;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_day27_serial_comparator.sv
// Self-checking bench for day27_serial_comparator with K = 20.
// Directed vectors come from a table. Random pairs are checked against a behavioural
// model that works out the expected result from operand magnitude and XOR arithmetic.
`timescale 1ns/1ps
module tb_day27_serial_comparator;

  localparam int K  = 20;
  localparam int CW = $clog2(K + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [K-1:0]  a = '0;
  logic [K-1:0]  b = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          a_equal_b;
  logic          a_greater_b;
  logic          b_greater_a;
  logic [CW-1:0] cycles;

  int tests = 0;
  int fails = 0;

  day27_serial_comparator #(.K(K), .CW(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .a_equal_b   (a_equal_b),
    .a_greater_b (a_greater_b),
    .b_greater_a (b_greater_a),
    .cycles      (cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [K-1:0] va;
    logic [K-1:0] vb;
    int           stall;
    logic         e_eq;
    logic         e_gt;
    logic         e_lt;
    int           e_n;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: positions examined = K - (index of highest set bit of a^b), or K if equal.
  function automatic int ref_n(input logic [K-1:0] x, input logic [K-1:0] y);
    logic [K-1:0] d;
    int p;
    d = x ^ y;
    if (d == '0) return K;
    p = 0;
    while (d > 1) begin
      d = d >> 1;
      p++;
    end
    return K - p;
  endfunction

  // One complete transaction: capture, wait for the result, optionally stall, then release.
  task automatic run_txn(input logic [K-1:0] ta, input logic [K-1:0] tbv, input int stall,
                         input logic e_eq, input logic e_gt, input logic e_lt,
                         input int e_n, input string id);
    int edges;
    logic [CW-1:0] held_cycles;
    @(negedge clk);
    check({id, "_in_ready_idle"}, 32'(in_ready), 32'(1));
    in_valid  = 1'b1;
    a         = ta;
    b         = tbv;
    out_ready = (stall == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = K'($urandom_range(0, 20'hFFFFF));
    b = K'($urandom_range(0, 20'hFFFFF));
    check({id, "_in_ready_busy"}, 32'(in_ready), 32'(0));
    edges = 0;
    while (out_valid !== 1'b1 && edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
    end
    if (out_valid !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: out_valid never rose within %0d edges", id, edges);
      return;
    end
    check({id, "_latency"}, 32'(edges), 32'(e_n));
    check({id, "_eq"}, 32'(a_equal_b), 32'(e_eq));
    check({id, "_gt"}, 32'(a_greater_b), 32'(e_gt));
    check({id, "_lt"}, 32'(b_greater_a), 32'(e_lt));
    check({id, "_cycles"}, 32'(cycles), 32'(e_n));
    check({id, "_onehot"}, 32'(a_equal_b) + 32'(a_greater_b) + 32'(b_greater_a), 32'(1));
    held_cycles = cycles;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = K'($urandom_range(0, 20'hFFFFF));
      b = K'($urandom_range(0, 20'hFFFFF));
      @(posedge clk);
      #1;
      check({id, "_hold_valid"}, 32'(out_valid), 32'(1));
      check({id, "_hold_flags"}, {29'd0, a_equal_b, a_greater_b, b_greater_a},
            {29'd0, e_eq, e_gt, e_lt});
      check({id, "_hold_cycles"}, 32'(cycles), 32'(held_cycles));
      check({id, "_hold_in_ready"}, 32'(in_ready), 32'(0));
    end
    if (stall > 0) begin
      @(negedge clk);
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check({id, "_release_valid"}, 32'(out_valid), 32'(0));
    check({id, "_release_flags"}, {29'd0, a_equal_b, a_greater_b, b_greater_a}, 32'(0));
    check({id, "_release_in_ready"}, 32'(in_ready), 32'(1));
    check({id, "_cycles_kept"}, 32'(cycles), 32'(e_n));
    @(negedge clk);
    in_valid = 1'b0;
    check({id, "_no_early_accept"}, 32'(in_ready), 32'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    logic [K-1:0] ra, rb;

    vecs[0] = '{20'h80000, 20'h7FFFF, 0, 1'b0, 1'b1, 1'b0, 1};
    vecs[1] = '{20'hABCDE, 20'hABCDE, 0, 1'b1, 1'b0, 1'b0, 20};
    vecs[2] = '{20'h00000, 20'h00000, 0, 1'b1, 1'b0, 1'b0, 20};
    vecs[3] = '{20'h00000, 20'h00001, 0, 1'b0, 1'b0, 1'b1, 20};
    vecs[4] = '{20'h00001, 20'h00000, 0, 1'b0, 1'b1, 1'b0, 20};
    vecs[5] = '{20'h00400, 20'h00200, 5, 1'b0, 1'b1, 1'b0, 10};
    vecs[6] = '{20'h40000, 20'h80000, 0, 1'b0, 1'b0, 1'b1, 1};

    // Reset values, checked before any clock edge is seen.
    #2;
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_flags", {29'd0, a_equal_b, a_greater_b, b_greater_a}, 32'(0));
    check("rst_cycles", 32'(cycles), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      run_txn(vecs[i].va, vecs[i].vb, vecs[i].stall, vecs[i].e_eq, vecs[i].e_gt,
              vecs[i].e_lt, vecs[i].e_n, $sformatf("vec%0d", i));

    // Reset asserted mid-scan: outputs clear asynchronously and no result appears.
    @(negedge clk);
    in_valid = 1'b1;
    a = 20'h00001;
    b = 20'h00000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'(1));
    check("midrst_out_valid", 32'(out_valid), 32'(0));
    check("midrst_flags", {29'd0, a_equal_b, a_greater_b, b_greater_a}, 32'(0));
    check("midrst_cycles", 32'(cycles), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (out_valid) pulses++;
    end
    check("midrst_no_pulse", 32'(pulses), 32'(0));
    run_txn(20'h12345, 20'h12344, 0, 1'b0, 1'b1, 1'b0, 20, "post_rst");

    // Random pairs checked against the behavioural model.
    for (int i = 0; i < 10; i++) begin
      ra = K'($urandom_range(0, 20'hFFFFF));
      rb = K'($urandom_range(0, 20'hFFFFF));
      if (i == 9) rb = ra;
      run_txn(ra, rb, (i % 3 == 1) ? 2 : 0, ra == rb, ra > rb, rb > ra, ref_n(ra, rb),
              $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
